ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
- Drives a configuration chain of DFFs that shift one position per enabled prog_clk edge. The chain is fed at ccff_head and ends at ccff_tail.
- Accepts bitstream words over a valid/ready stream and serializes them MSB-first onto the chain head for exactly CHAIN_LEN shifts.
- On every shift it captures the bit leaving ccff_tail and returns the previous chain contents as readback words.
- Sits between the configuration port and each fabric configuration chain.

Parameters:
- CHAIN_LEN, 5: number of DFFs in the driven chain; total shifts per load (>=1).
- WORD_W, 8: width of input and readback words (>=2).
- CNT_W, $clog2(CHAIN_LEN+1): width of the shift counter.

Ports:
- prog_clk  in  1  configuration clock; drives this block and the chain.
- prog_reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a load fully completes.
- s_data  in  WORD_W  bitstream word; the MSB is shifted first.
- s_valid  in  1  s_data valid.
- s_ready  out  1  block accepts s_data this cycle.
- ccff_head  out  1  serial data into the chain.
- prog_en  out  1  chain shift enable; the chain shifts on prog_clk edges where prog_en=1.
- ccff_tail  in  1  serial data out of the chain's last DFF.
- rb_data  out  WORD_W  readback word; the first bit out of the chain is the MSB.
- rb_valid  out  1  rb_data valid; held until accepted.
- rb_ready  in  1  consumer accepts rb_data.

Behaviour:
- Reset (async, prog_reset=1): state=IDLE; counters and shift registers cleared; busy=0, done=0, s_ready=0, prog_en=0, ccff_head=0, rb_valid=0, rb_data=0.
- Reset mid-load aborts immediately. prog_en drops asynchronously. Chain contents are then undefined and software must reload.
- IDLE:
  - start=1 -> FETCH; shift counter=0; capture count=0.
  - start while busy is ignored.
- FETCH:
  - s_ready=1; no other state asserts s_ready.
  - On s_valid=1, latch s_data into the tx shift register and set the word-bit count to WORD_W -> SHIFT.
- SHIFT: a cycle is a shift cycle when (rb_valid=0 or rb_ready=1).
  - In a shift cycle: prog_en=1, ccff_head=tx_sr[WORD_W-1]. The tx register shifts left by one. ccff_tail is shifted into the LSB of the capture register. Shift counter and capture count increment; word-bit count decrements.
  - In a stall cycle: prog_en=0; all registers hold.
  - prog_en is decoded from state and stall only. ccff_head is the tx register MSB.
- Capture:
  - When capture count reaches WORD_W, or the shift counter reaches CHAIN_LEN, the capture register is transferred to rb_data next cycle with rb_valid=1. Capture count is cleared.
  - A partial final word is left-justified: the first captured bit sits in the MSB and the low bits are zero.
  - rb_valid clears on rb_valid & rb_ready. A new word and an accept in the same cycle load the new word with rb_valid kept at 1.
- End of word / end of load:
  - After the shift that makes the shift counter equal CHAIN_LEN -> FINISH, regardless of remaining word bits. Unused low bits of the last input word are discarded.
  - Else, after the shift where word-bit count reaches 0 -> FETCH.
- FINISH:
  - Waits until rb_valid=0, including a same-cycle accept, then pulses done=1 for one cycle -> IDLE.
  - start in the done cycle is ignored.
- Timing: with s_valid and rb_ready held at 1, each word costs 1 FETCH cycle plus min(WORD_W, remaining) shift cycles.
- After a complete load, chain DFF k (0 = nearest head) holds input bit CHAIN_LEN-1-k of the stream.

Test Plan:
- Reset chain model to 0; start; s_data=0xA8 (CHAIN_LEN=5, WORD_W=8) -> prog_en high exactly 5 cycles (cycles 2-6); chain mem_out[0:4]=1,0,1,0,1; rb_data=0x00; done pulses once.
- Second load s_data=0x50 after the first -> chain mem_out[0:4]=0,1,0,1,0; rb_data=0xA8 (round trip of the previous contents).
- CHAIN_LEN=20, WORD_W=8, words 0xFF,0x00,0xF0 -> 3 FETCH cycles; 20 prog_en cycles; readback words emitted after bits 8, 16 and 20; third readback word has its low 4 bits zero.
- rb_ready held 0 for 10 cycles while rb_valid is pending -> prog_en=0 and ccff_head stable for those cycles; shifting resumes on the cycle rb_ready=1; no bit is lost or duplicated.
- s_valid withheld 5 cycles in FETCH -> s_ready stays 1, prog_en=0 and busy=1 throughout; then normal completion.
- Assert prog_reset during the 3rd shift -> prog_en=0 within the same cycle, all outputs at reset values; start then performs a full correct 5-bit load; start pulsed while busy -> no effect.

Source files
------------

// File: rtl/ccff_chain_loader_if.sv
// Handshake and chain bundle between a configuration controller and the chain loader.
// master: controller/chain side (drives start, s_data/s_valid, rb_ready, ccff_tail).
// slave:  loader side (drives busy, done, s_ready, ccff_head, prog_en, rb_data/rb_valid).
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
);
    logic              start;
    logic              busy;
    logic              done;
    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              ccff_head;
    logic              prog_en;
    logic              ccff_tail;
    logic [WORD_W-1:0] rb_data;
    logic              rb_valid;
    logic              rb_ready;

    modport master (
        output start, s_data, s_valid, ccff_tail, rb_ready,
        input  busy, done, s_ready, ccff_head, prog_en, rb_data, rb_valid
    );

    modport slave (
        input  start, s_data, s_valid, ccff_tail, rb_ready,
        output busy, done, s_ready, ccff_head, prog_en, rb_data, rb_valid
    );
endinterface

// File: rtl/ccff_chain_loader.sv
// Serializes bitstream words MSB-first onto a CHAIN_LEN-deep config chain, returning old contents as readback words.
// Latency: per word 1 fetch cycle + min(WORD_W, remaining) shift cycles; done pulses in the cycle after the last shift at the earliest.
// Backpressure: s_ready only in FETCH; shifting stalls (prog_en=0, all state held) while a readback word is pending and not accepted.
//
// Ports: prog_clk/prog_reset (async, active-high) plain; everything else via bus (slave modport):
//   start/busy/done control, s_data/s_valid/s_ready input words, ccff_head/prog_en/ccff_tail chain,
//   rb_data/rb_valid/rb_ready readback words.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 5,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic               prog_clk,
    input  logic               prog_reset,
    ccff_chain_loader_if.slave bus
);
    localparam int BCW = $clog2(WORD_W + 1);

    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] SHIFT_ONE  = CNT_W'(1);
    localparam logic [BCW-1:0]   WORD_LAST  = BCW'(WORD_W - 1);
    localparam logic [BCW-1:0]   WORD_FULL  = BCW'(WORD_W);
    localparam logic [BCW-1:0]   BIT_ONE    = BCW'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_FINISH
    } state_t;

    state_t            state_q,     state_d;
    logic [CNT_W-1:0]  shift_cnt_q, shift_cnt_d;  // shifts done in this load
    logic [BCW-1:0]    bit_cnt_q,   bit_cnt_d;    // bits left in the current input word
    logic [BCW-1:0]    cap_cnt_q,   cap_cnt_d;    // bits collected in the capture register
    logic [WORD_W-1:0] tx_sr_q,     tx_sr_d;
    logic [WORD_W-1:0] cap_sr_q,    cap_sr_d;
    logic [WORD_W-1:0] rb_data_q,   rb_data_d;
    logic              rb_valid_q,  rb_valid_d;

    logic              rb_free;
    logic [WORD_W-1:0] cap_sr_shf;
    logic [BCW-1:0]    cap_cnt_inc;

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state_q     <= ST_IDLE;
            shift_cnt_q <= '0;
            bit_cnt_q   <= '0;
            cap_cnt_q   <= '0;
            tx_sr_q     <= '0;
            cap_sr_q    <= '0;
            rb_data_q   <= '0;
            rb_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_cnt_q <= shift_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
            tx_sr_q     <= tx_sr_d;
            cap_sr_q    <= cap_sr_d;
            rb_data_q   <= rb_data_d;
            rb_valid_q  <= rb_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_cnt_d = shift_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        tx_sr_d     = tx_sr_q;
        cap_sr_d    = cap_sr_q;
        rb_data_d   = rb_data_q;
        rb_valid_d  = rb_valid_q;
        bus.s_ready = 1'b0;
        bus.prog_en = 1'b0;
        bus.done    = 1'b0;

        // The readback slot is usable this cycle if empty or being drained now;
        // this gates both shifting and the final done handshake.
        rb_free     = !rb_valid_q || bus.rb_ready;
        cap_sr_shf  = {cap_sr_q[WORD_W-2:0], bus.ccff_tail};
        cap_cnt_inc = cap_cnt_q + BIT_ONE;

        if (rb_valid_q && bus.rb_ready) begin
            rb_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d     = ST_FETCH;
                    shift_cnt_d = '0;
                    cap_cnt_d   = '0;
                    cap_sr_d    = '0;
                end
            end

            ST_FETCH: begin
                bus.s_ready = 1'b1;
                if (bus.s_valid) begin
                    tx_sr_d   = bus.s_data;
                    bit_cnt_d = WORD_FULL;
                    state_d   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (rb_free) begin
                    bus.prog_en = 1'b1;
                    tx_sr_d     = {tx_sr_q[WORD_W-2:0], 1'b0};
                    cap_sr_d    = cap_sr_shf;
                    cap_cnt_d   = cap_cnt_inc;
                    shift_cnt_d = shift_cnt_q + SHIFT_ONE;
                    bit_cnt_d   = bit_cnt_q - BIT_ONE;

                    // Word complete (full or end of chain): publish it straight from
                    // the freshly shifted capture value. rb_free guarantees the slot
                    // is empty or drained this same cycle, so nothing is overwritten.
                    // A short last word is left-justified (first bit out in the MSB).
                    if (cap_cnt_q == WORD_LAST || shift_cnt_q == SHIFT_LAST) begin
                        rb_data_d  = cap_sr_shf << (WORD_FULL - cap_cnt_inc);
                        rb_valid_d = 1'b1;
                        cap_cnt_d  = '0;
                        cap_sr_d   = '0;
                    end

                    // End of chain wins over end of word: leftover input bits are dropped.
                    if (shift_cnt_q == SHIFT_LAST) begin
                        state_d = ST_FINISH;
                    end else if (bit_cnt_q == BIT_ONE) begin
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_FINISH: begin
                if (rb_free) begin
                    bus.done = 1'b1;
                    state_d  = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.ccff_head = tx_sr_q[WORD_W-1];
    assign bus.rb_data   = rb_data_q;
    assign bus.rb_valid  = rb_valid_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader with a behavioural chain of DFFs on the serial port.
// Expected readback words are queued when a load is issued; a negedge monitor pops them on each accept.
// Readback of a load equals the previous load's first CHAIN_LEN stream bits, chunked and left-justified.
module tb_ccff_chain_loader;
    localparam int L  = 20;
    localparam int W  = 8;
    localparam int NW = (L + W - 1) / W;

    logic prog_clk;
    logic prog_reset;

    ccff_chain_loader_if #(.WORD_W(W)) bus ();

    ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W)) dut (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .bus        (bus)
    );

    initial begin
        prog_clk = 1'b0;
        forever #5 prog_clk = ~prog_clk;
    end

    // Configuration chain: DFF 0 nearest the head, tail is DFF L-1.
    logic [L-1:0] chain_q;
    logic         chain_clr;
    always @(posedge prog_clk) begin
        if (chain_clr)        chain_q <= '0;
        else if (bus.prog_en) chain_q <= {chain_q[L-2:0], bus.ccff_head};
    end
    assign bus.ccff_tail = chain_q[L-1];

    int cyc = 0;
    always @(posedge prog_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Stimulus controls, written only by the main process.
    logic [W-1:0] ld_words[$];
    int ld_gen         = 0;
    int sv_block_until = 0;
    int sv_pct         = 100;
    int rdy_pct        = 100;
    int rb_block_from  = 0;
    int rb_block_until = 0;

    // Scoreboard and monitor totals.
    logic [W-1:0] exp_q[$];
    int en_total   = 0;
    int done_total = 0;
    int acc_total  = 0;

    bit prev_bits[L];
    bit cur_bits[L];

    // Input word feeder.
    initial begin
        int my_gen;
        int idx;
        bit hs;
        my_gen = 0;
        idx = 0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        forever begin
            @(negedge prog_clk);
            hs = bus.s_valid && bus.s_ready && !prog_reset;
            @(posedge prog_clk);
            #2;
            if (hs) begin
                idx++;
                bus.s_valid = 1'b0;
            end
            if (my_gen != ld_gen) begin
                my_gen = ld_gen;
                idx = 0;
                bus.s_valid = 1'b0;
            end
            if (!bus.s_valid && idx < ld_words.size() && cyc >= sv_block_until &&
                $urandom_range(99) < sv_pct) begin
                bus.s_valid = 1'b1;
                bus.s_data  = ld_words[idx];
            end
        end
    end

    // Readback consumer.
    initial begin
        bus.rb_ready = 1'b1;
        forever begin
            @(posedge prog_clk);
            #2;
            bus.rb_ready = !(cyc >= rb_block_from && cyc < rb_block_until) &&
                           ($urandom_range(99) < rdy_pct);
        end
    end

    // Monitor.
    initial begin
        bit prev_hold;
        logic [W-1:0] prev_rb;
        prev_hold = 1'b0;
        prev_rb = '0;
        forever begin
            @(negedge prog_clk);
            if (prog_reset) begin
                prev_hold = 1'b0;
            end else begin
                if (bus.prog_en) en_total++;
                if (bus.done)    done_total++;
                if (bus.s_valid && bus.s_ready) acc_total++;
                if (prev_hold) check("rb_held", {bus.rb_valid, bus.rb_data}, {1'b1, prev_rb});
                if (bus.rb_valid && !bus.rb_ready) check("stall_prog_en", bus.prog_en, 1'b0);
                if (bus.rb_valid && bus.rb_ready) begin
                    if (exp_q.size() == 0) check("rb_unexpected_word", 1, 0);
                    else check("rb_data", bus.rb_data, exp_q.pop_front());
                end
                prev_hold = bus.rb_valid && !bus.rb_ready;
                prev_rb   = bus.rb_data;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},      bus.busy,      1'b0);
        check({tag, "_done"},      bus.done,      1'b0);
        check({tag, "_s_ready"},   bus.s_ready,   1'b0);
        check({tag, "_prog_en"},   bus.prog_en,   1'b0);
        check({tag, "_ccff_head"}, bus.ccff_head, 1'b0);
        check({tag, "_rb_valid"},  bus.rb_valid,  1'b0);
        check({tag, "_rb_data"},   bus.rb_data,   '0);
    endtask

    // One complete load. exp_lat < 0 skips the exact done-latency check.
    task automatic run_load(input logic [NW*W-1:0] wv, input int exp_lat, input int sv_hold,
                            input bit poke_busy, input bit rb_stall);
        int st_cyc, done_cyc, en0, acc0, done0, t;
        logic [W-1:0] e;
        logic [L-1:0] exp_chain;

        for (int w = 0; w < NW; w++) begin
            e = '0;
            for (int j = 0; j < W; j++)
                if (w * W + j < L) e[W-1-j] = prev_bits[w * W + j];
            exp_q.push_back(e);
        end
        for (int i = 0; i < L; i++) cur_bits[i] = wv[NW*W-1-i];
        for (int k = 0; k < L; k++) exp_chain[k] = cur_bits[L-1-k];

        ld_words.delete();
        for (int w = 0; w < NW; w++) ld_words.push_back(wv[(NW-w)*W-1 -: W]);
        en0   = en_total;
        acc0  = acc_total;
        done0 = done_total;

        @(posedge prog_clk);
        #1;
        sv_block_until = cyc + sv_hold + 2;
        rb_block_from  = rb_stall ? cyc + 6  : 0;
        rb_block_until = rb_stall ? cyc + 16 : 0;
        ld_gen++;
        @(posedge prog_clk);
        #1;
        bus.start = 1'b1;
        st_cyc = cyc;
        @(posedge prog_clk);
        #1;
        bus.start = 1'b0;
        for (int k = 0; k < sv_hold; k++) begin
            @(negedge prog_clk);
            #1;
            check("fetch_wait_busy",    bus.busy,    1'b1);
            check("fetch_wait_s_ready", bus.s_ready, 1'b1);
            check("fetch_wait_prog_en", bus.prog_en, 1'b0);
        end
        if (poke_busy) begin
            @(posedge prog_clk);
            #1;
            bus.start = 1'b1;
            @(posedge prog_clk);
            #1;
            bus.start = 1'b0;
        end

        t = 0;
        while (done_total == done0 && t < 3000) begin
            @(negedge prog_clk);
            #1;
            t++;
        end
        check("load_done_seen", done_total != done0, 1'b1);
        done_cyc = cyc;
        if (exp_lat >= 0) check("done_latency", done_cyc - st_cyc, exp_lat);

        // start in the done cycle must be ignored
        bus.start = 1'b1;
        @(posedge prog_clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(negedge prog_clk);
        #1;
        check("idle_after_done",  bus.busy, 1'b0);
        check("prog_en_cycles",   en_total - en0, L);
        check("words_fetched",    acc_total - acc0, NW);
        check("done_pulses",      done_total - done0, 1);
        check("readback_drained", exp_q.size(), 0);
        check("chain_contents",   chain_q, exp_chain);
        for (int i = 0; i < L; i++) prev_bits[i] = cur_bits[i];
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen, t;
        bus.start  = 1'b0;
        prog_reset = 1'b1;
        chain_clr  = 1'b1;
        repeat (3) @(negedge prog_clk);
        check_reset_outputs("reset");
        prog_reset = 1'b0;
        chain_clr  = 1'b0;
        repeat (2) @(negedge prog_clk);

        // Directed: back-to-back loads, exact timing, start while busy ignored.
        run_load(24'hFF00F0, NW + L + 1, 0, 1'b1, 1'b0);
        // FETCH starved for 5 cycles.
        run_load(24'hA53C96, NW + L + 1 + 5, 5, 1'b0, 1'b0);
        // Readback consumer blocked for 10 cycles mid-load.
        run_load(24'h0F5A81, -1, 0, 1'b0, 1'b1);

        // Reset during the 3rd shift.
        ld_words.delete();
        for (int w = 0; w < NW; w++) ld_words.push_back(W'($urandom));
        @(posedge prog_clk);
        #1;
        sv_block_until = cyc + 2;
        ld_gen++;
        @(posedge prog_clk);
        #1;
        bus.start = 1'b1;
        @(posedge prog_clk);
        #1;
        bus.start = 1'b0;
        seen = 0;
        t = 0;
        while (seen < 3 && t < 200) begin
            @(negedge prog_clk);
            #1;
            if (bus.prog_en) seen++;
            t++;
        end
        check("abort_third_shift_reached", seen, 3);
        prog_reset = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(posedge prog_clk);
        #1;
        chain_clr = 1'b1;
        @(posedge prog_clk);
        #1;
        chain_clr = 1'b0;
        exp_q.delete();
        for (int i = 0; i < L; i++) prev_bits[i] = 1'b0;
        @(negedge prog_clk);
        prog_reset = 1'b0;
        repeat (2) @(negedge prog_clk);

        // Full load after the abort, then randomized loads.
        run_load(24'hC3E718, NW + L + 1, 0, 1'b1, 1'b0);
        for (int n = 0; n < 8; n++) begin
            rdy_pct = $urandom_range(100, 30);
            sv_pct  = $urandom_range(100, 50);
            run_load((NW*W)'($urandom), -1, 0, ($urandom_range(1) == 1), ($urandom_range(1) == 1));
        end
        rdy_pct = 100;
        sv_pct  = 100;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
